oci_mem_access_sequencer: RTL and testbench

Sequences debug-monitor accesses to the on-chip instruction memory (OCI RAM) from the system-clock debug command strobes. It decodes `take_action_ocimem_a/b` and `jdo`, drives a single-port memory request/wait/rvalid interface, and returns results and status on `MonDReg`, `monitor_ready` and `monitor_error` to the debug slave TCK side. There is one instance per CPU, between the debug slave sysclk logic and the OCI RAM.

---
 rtl/oci_mem_access_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_oci_mem_access_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oci_mem_access_sequencer.sv
// Debug-monitor sequencer for OCI RAM accesses: decodes ocimem strobes, drives the RAM request port.
// Optional build macro OCI_MEM_SEQ_AUTOINC_EN: post-increment the address after ocimem_b accesses.
module oci_mem_access_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_wait,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_RDWAIT = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt, w_addr_inc;
  logic              r_rd, w_rd_nxt;
  logic              r_wr, w_wr_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic [31:0]       r_rdata, w_rdata_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_error, w_error_nxt;
  logic [15:0]       r_cnt, w_cnt_nxt;
  logic              w_start, w_done, w_timeout, w_overrun, w_cnt_last;
  logic              w_unused_jdo;

  assign w_unused_jdo = ^{jdo[37:36], jdo[1:0]};
  assign w_cnt_last   = (r_cnt >= CNT_LAST);
  assign w_overrun    = (r_state != ST_IDLE) && (take_action_ocimem_a || take_action_ocimem_b);

`ifdef OCI_MEM_SEQ_AUTOINC_EN
  logic r_from_b, w_from_b_nxt;

  // Only ocimem_b-initiated accesses advance the address on completion.
  assign w_addr_inc   = r_from_b ? (r_addr + ADDR_W'(1'b1)) : r_addr;
  assign w_from_b_nxt = w_start ? ~take_action_ocimem_a : r_from_b;

  // Origin-of-access flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_from_b <= 1'b0;
    end else begin
      r_from_b <= w_from_b_nxt;
    end
  end
`else
  assign w_addr_inc = r_addr;
`endif

  // Next-state and next-output decode for the access sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rd_nxt    = r_rd;
    w_wr_nxt    = r_wr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (take_action_ocimem_a) begin
          w_addr_nxt = jdo[ADDR_W+1:2];
          if (jdo[35]) begin
            w_rd_nxt = 1'b1;
            w_start  = 1'b1;
          end else begin
            w_start  = 1'b0;
          end
        end else if (take_action_ocimem_b) begin
          w_start = 1'b1;
          if (jdo[35]) begin
            w_wr_nxt    = 1'b1;
            w_wdata_nxt = jdo[34:3];
          end else begin
            w_rd_nxt    = 1'b1;
          end
        end else begin
          w_start = 1'b0;
        end
        if (w_start) begin
          w_state_nxt = ST_REQ;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Timeout outranks a read acceptance so RDWAIT is never entered past the limit.
        if (!mem_wait && r_wr) begin
          w_wr_nxt    = 1'b0;
          w_done      = 1'b1;
          w_addr_nxt  = w_addr_inc;
          w_state_nxt = ST_IDLE;
        end else if (w_cnt_last) begin
          w_rd_nxt    = 1'b0;
          w_wr_nxt    = 1'b0;
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!mem_wait) begin
          w_rd_nxt    = 1'b0;
          w_cnt_nxt   = r_cnt + 16'd1;
          w_state_nxt = ST_RDWAIT;
        end else begin
          w_cnt_nxt   = r_cnt + 16'd1;
        end
      end
      ST_RDWAIT: begin
        if (mem_rvalid) begin
          w_rdata_nxt = mem_rdata;
          w_done      = 1'b1;
          w_addr_nxt  = w_addr_inc;
          w_state_nxt = ST_IDLE;
        end else if (w_cnt_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + 16'd1;
        end
      end
      default: begin
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_timeout || w_overrun) begin
      w_error_nxt = 1'b1;
    end else if (take_no_action_ocimem_a) begin
      w_error_nxt = 1'b0;
    end else begin
      w_error_nxt = r_error;
    end

    if (w_done || w_timeout) begin
      w_ready_nxt = 1'b1;
    end else if (w_start || take_no_action_ocimem_a) begin
      w_ready_nxt = 1'b0;
    end else begin
      w_ready_nxt = r_ready;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_rd    <= w_rd_nxt;
      r_wr    <= w_wr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
      r_ready <= w_ready_nxt;
      r_error <= w_error_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign mem_addr      = r_addr;
  assign mem_rd        = r_rd;
  assign mem_wr        = r_wr;
  assign mem_wdata     = r_wdata;
  assign MonDReg       = r_rdata;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;

endmodule

// File: tb/tb_oci_mem_access_sequencer.sv
// Self-checking bench for oci_mem_access_sequencer: vector table with a bench RAM model and scoreboard,
// plus hand sequences for timeout, overrun, collision, stray rvalid and reset mid-read.
module tb_oci_mem_access_sequencer;

  localparam int TIMEOUT = 8;
`ifdef OCI_MEM_SEQ_AUTOINC_EN
  localparam logic [7:0] INC = 8'd1;
`else
  localparam logic [7:0] INC = 8'd0;
`endif

  logic        clk, reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [7:0]  mem_addr;
  logic        mem_rd, mem_wr, mem_wait, mem_rvalid;
  logic [31:0] mem_wdata, mem_rdata, MonDReg;
  logic        monitor_ready, monitor_error;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    int          waitc;
    int          rvlat;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } sb_t;

  logic [31:0] ram [0:255];
  sb_t         sb_q[$];
  vec_t        vecs[9];
  logic [31:0] last_rd;
  int          n_cmp, n_err;

  oci_mem_access_sequencer #(.ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .mem_addr                (mem_addr),
    .mem_rd                  (mem_rd),
    .mem_wr                  (mem_wr),
    .mem_wdata               (mem_wdata),
    .mem_wait                (mem_wait),
    .mem_rdata               (mem_rdata),
    .mem_rvalid              (mem_rvalid),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic strobe_a(input logic [7:0] addr, input logic rd);
    jdo = {2'b00, rd, 25'd0, addr, 2'b00};
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    jdo = 38'd0;
    chk("a_addr", 32'(mem_addr), 32'(addr));
  endtask

  task automatic no_action();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  // One ocimem_b access at the current address, served by the bench RAM model.
  task automatic do_b(input vec_t v);
    sb_t        e;
    logic [7:0] rd_addr;
    e.wr = v.wr; e.addr = v.addr; e.data = v.data;
    sb_q.push_back(e);
    jdo = v.wr ? {2'b00, 1'b1, v.data, 3'b000} : 38'd0;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    jdo = 38'd0;
    chk("ready_clr", 32'(monitor_ready), 32'd0);
    mem_wait = 1'b1;
    for (int w = 0; w < v.waitc; w++) begin
      chk("stall_req", 32'(v.wr ? mem_wr : mem_rd), 32'd1);
      chk("stall_addr", 32'(mem_addr), 32'(v.addr));
      if (v.wr) chk("stall_wdata", mem_wdata, v.data);
      tick();
    end
    mem_wait = 1'b0;
    e = sb_q.pop_front();
    chk("acc_req", 32'(e.wr ? mem_wr : mem_rd), 32'd1);
    chk("acc_addr", 32'(mem_addr), 32'(e.addr));
    rd_addr = mem_addr;
    if (e.wr) begin
      chk("acc_wdata", mem_wdata, e.data);
      if (mem_wr) ram[mem_addr] = mem_wdata;
      tick();
    end else begin
      tick();
      chk("rd_dropped", 32'(mem_rd), 32'd0);
      for (int k = 1; k < v.rvlat; k++) tick();
      mem_rvalid = 1'b1;
      mem_rdata  = ram[rd_addr];
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
      chk("rd_data", MonDReg, e.data);
      last_rd = e.data;
    end
    chk("done_ready", 32'(monitor_ready), 32'd1);
    chk("done_error", 32'(monitor_error), 32'd0);
    chk("done_idle", 32'({mem_rd, mem_wr}), 32'd0);
    chk("post_addr", 32'(mem_addr), 32'(v.addr + INC));
  endtask

  initial begin
    vec_t v;
    n_cmp = 0; n_err = 0; last_rd = 32'd0;
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    ram[8'h10] = 32'hDEADBEEF;
    vecs[0] = '{1'b0, 8'h10, 32'hDEADBEEF, 0, 2};
    vecs[1] = '{1'b1, 8'h20, 32'hA5A55A5A, 0, 1};
    vecs[2] = '{1'b0, 8'h20, 32'hA5A55A5A, 1, 1};
    vecs[3] = '{1'b1, 8'h00, 32'h00000001, 5, 1};
    vecs[4] = '{1'b0, 8'h00, 32'h00000001, 0, 3};
    vecs[5] = '{1'b1, 8'hFF, 32'h0F0F0F0F, 0, 1};
    vecs[6] = '{1'b0, 8'hFF, 32'h0F0F0F0F, 2, 1};
    vecs[7] = '{1'b1, 8'h7E, 32'hFFFFFFFF, 0, 1};
    vecs[8] = '{1'b0, 8'h7E, 32'hFFFFFFFF, 0, 4};

    reset = 1'b1; jdo = 38'd0; mem_wait = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_req", 32'({mem_rd, mem_wr}), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_mondreg", MonDReg, 32'd0);
    chk("rst_status", 32'({monitor_ready, monitor_error}), 32'd0);

    for (int i = 0; i < 9; i++) begin
      strobe_a(vecs[i].addr, 1'b0);
      do_b(vecs[i]);
    end

    // Address wrap: second write goes to 0x00 only when auto-increment is built in.
    strobe_a(8'hFF, 1'b0);
    v = '{1'b1, 8'hFF, 32'h12345678, 0, 1};
    do_b(v);
    v = '{1'b1, 8'hFF + INC, 32'hCAFEF00D, 0, 1};
    do_b(v);
    chk("wrap_ram_ff", ram[8'hFF], (INC != 8'd0) ? 32'h12345678 : 32'hCAFEF00D);
    chk("wrap_ram_00", ram[8'h00], (INC != 8'd0) ? 32'hCAFEF00D : 32'h00000001);

    // Timeout: ocimem_a-started read that is never accepted.
    mem_wait = 1'b1;
    strobe_a(8'h33, 1'b1);
    chk("to_rd", 32'(mem_rd), 32'd1);
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      chk("to_err", 32'(monitor_error), (i == TIMEOUT) ? 32'd1 : 32'd0);
    end
    mem_wait = 1'b0;
    chk("to_rd_drop", 32'(mem_rd), 32'd0);
    chk("to_ready", 32'(monitor_ready), 32'd1);
    chk("to_mondreg", MonDReg, last_rd);
    chk("to_addr", 32'(mem_addr), 32'h33);
    no_action();
    chk("to_clear", 32'({monitor_ready, monitor_error}), 32'd0);

    // Overrun during RDWAIT, clear, then clear+error in the same cycle.
    strobe_a(8'h10, 1'b0);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    tick();
    chk("ov_rdwait", 32'({mem_rd, mem_wr}), 32'd0);
    jdo = {2'b00, 1'b1, 32'h0BAD0BAD, 3'b000};
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    jdo = 38'd0;
    chk("ov_err", 32'(monitor_error), 32'd1);
    chk("ov_no_wr", 32'({mem_rd, mem_wr}), 32'd0);
    no_action();
    chk("ov_cleared", 32'(monitor_error), 32'd0);
    jdo = {2'b00, 1'b1, 25'd0, 8'h55, 2'b00};
    take_action_ocimem_a = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = 38'd0;
    chk("ov_set_wins", 32'(monitor_error), 32'd1);
    chk("ov_addr_kept", 32'(mem_addr), 32'h10);
    mem_rvalid = 1'b1;
    mem_rdata  = ram[8'h10];
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    chk("ov_rd_data", MonDReg, 32'hDEADBEEF);
    chk("ov_status", 32'({monitor_ready, monitor_error}), 32'd3);
    chk("ov_post_addr", 32'(mem_addr), 32'(8'h10 + INC));

    // Collision: ocimem_a and ocimem_b together only load the address.
    no_action();
    jdo = {2'b00, 1'b0, 25'd0, 8'h44, 2'b00};
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    jdo = 38'd0;
    chk("col_addr", 32'(mem_addr), 32'h44);
    chk("col_no_req", 32'({mem_rd, mem_wr}), 32'd0);
    chk("col_no_err", 32'(monitor_error), 32'd0);
    tick();
    chk("col_idle", 32'({mem_rd, mem_wr}), 32'd0);

    // Stray rvalid in IDLE.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11111111;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    chk("stray_mondreg", MonDReg, 32'hDEADBEEF);
    chk("stray_ready", 32'(monitor_ready), 32'd0);

    // Reset in RDWAIT, then a late rvalid.
    strobe_a(8'h20, 1'b0);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    tick();
    chk("rr_rdwait", 32'(mem_rd), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_addr", 32'(mem_addr), 32'd0);
    chk("rr_req", 32'({mem_rd, mem_wr}), 32'd0);
    chk("rr_wdata", mem_wdata, 32'd0);
    chk("rr_mondreg", MonDReg, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A55A5A;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    chk("rr_late_mondreg", MonDReg, 32'd0);
    chk("rr_status", 32'({monitor_ready, monitor_error}), 32'd0);
    strobe_a(8'h7E, 1'b0);
    v = '{1'b0, 8'h7E, 32'hFFFFFFFF, 0, 1};
    do_b(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
